// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: select encodings, handler addresses and the
// registered result payload of the datapath select block.
package mips_pkg;

   localparam int unsigned XLEN     = 32;
   localparam int unsigned REG_AW   = 5;
   localparam int unsigned IMM_W    = 16;
   localparam int unsigned PCSRC_W  = 3;
   localparam int unsigned REGDST_W = 2;
   localparam int unsigned WBSEL_W  = 2;

   localparam logic [XLEN-1:0]   ILLOP_ADDR = 32'h8000_0004;
   localparam logic [XLEN-1:0]   XADR_ADDR  = 32'h8000_0008;
   localparam logic [REG_AW-1:0] RA_REG     = 5'd31;
   localparam logic [REG_AW-1:0] XP_REG     = 5'd26;

   typedef enum logic [PCSRC_W-1:0] {
      PC_NEXT   = 3'd0,
      PC_BRANCH = 3'd1,
      PC_JUMP   = 3'd2,
      PC_JR     = 3'd3,
      PC_ILLOP  = 3'd4,
      PC_XADR   = 3'd5
   } pc_sel_e;

   typedef enum logic [REGDST_W-1:0] {
      RD_RD = 2'd0,
      RD_RT = 2'd1,
      RD_RA = 2'd2,
      RD_XP = 2'd3
   } reg_dst_e;

   typedef enum logic [WBSEL_W-1:0] {
      WB_ALU = 2'd0,
      WB_MEM = 2'd1,
      WB_PC4 = 2'd2,
      WB_PC  = 2'd3
   } wb_sel_e;

   typedef struct packed {
      logic [XLEN-1:0] alu_a;
      logic [XLEN-1:0] alu_b;
      logic [XLEN-1:0] next_pc;
      logic [XLEN-1:0] wr_reg;
      logic [XLEN-1:0] wb_data;
   } sel_result_t;

endpackage

// File: rtl/imm_extender.sv
// 16-bit immediate extension: zero-, sign- or load-upper form; LUOp wins over EXTOp.
module imm_extender
   import mips_pkg::*;
(
   input  logic [IMM_W-1:0] i_imm16,
   input  logic             i_ext_op,
   input  logic             i_lu_op,
   output logic [XLEN-1:0]  o_ext_c
);

   always_comb begin
      o_ext_c = {16'h0, i_imm16};
      if (i_lu_op)
         o_ext_c = {i_imm16, 16'h0};
      else if (i_ext_op)
         o_ext_c = {{16{i_imm16[IMM_W-1]}}, i_imm16};
   end

endmodule

// File: rtl/mux_choose_signal.sv
// Datapath select block: ALU operands, next PC, write register and write-back
// data, all registered one cycle after the selects are applied.
module mux_choose_signal
   import mips_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic [PCSRC_W-1:0]  PCSrc,
   input  logic [REGDST_W-1:0] RegDst,
   input  logic                ALUSrc1,
   input  logic                ALUSrc2,
   input  logic [WBSEL_W-1:0]  MemToReg,
   input  logic                EXTOp,
   input  logic                LUOp,
   input  logic [XLEN-1:0]     instruction,
   input  logic [XLEN-1:0]     DataBusA,
   input  logic [XLEN-1:0]     DataBusB,
   input  logic [XLEN-1:0]     ALUOUT,
   input  logic [XLEN-1:0]     ReadData,
   input  logic [XLEN-1:0]     PC,
   output logic [XLEN-1:0]     RESULT_ALUSrc1,
   output logic [XLEN-1:0]     RESULT_ALUSrc2,
   output logic [XLEN-1:0]     RESULT_PCSrc,
   output logic [XLEN-1:0]     RESULT_RegDst,
   output logic [XLEN-1:0]     RESULT_MemToReg
);

   logic [IMM_W-1:0]  w_imm16;
   logic [REG_AW-1:0] w_rs_unused_fld;
   logic [REG_AW-1:0] w_rt;
   logic [REG_AW-1:0] w_rd;
   logic [REG_AW-1:0] w_shamt;
   logic [5:0]        w_unused_op;
   logic [XLEN-1:0]   w_ext;
   logic [XLEN-1:0]   w_imm_sext;
   logic [XLEN-1:0]   w_pc4;
   logic [XLEN-1:0]   w_br;
   logic [XLEN-1:0]   w_jt;
   sel_result_t       w_next;
   sel_result_t       r_result;

   assign w_unused_op     = instruction[31:26];
   assign w_rs_unused_fld = instruction[25:21];
   assign w_rt            = instruction[20:16];
   assign w_rd            = instruction[15:11];
   assign w_shamt         = instruction[10:6];
   assign w_imm16         = instruction[15:0];

   imm_extender u_imm_extender (
      .i_imm16  (w_imm16),
      .i_ext_op (EXTOp),
      .i_lu_op  (LUOp),
      .o_ext_c  (w_ext)
   );

   // Branch offsets are always sign-extended, independent of EXTOp/LUOp.
   assign w_imm_sext = {{16{w_imm16[IMM_W-1]}}, w_imm16};
   assign w_pc4      = PC + 32'd4;
   assign w_br       = w_pc4 + (w_imm_sext << 2);
   assign w_jt       = {w_pc4[31:28], instruction[25:0], 2'b00};

   always_comb begin
      w_next = '0;

      w_next.alu_a = ALUSrc1 ? {27'b0, w_shamt} : DataBusA;
      w_next.alu_b = ALUSrc2 ? w_ext : DataBusB;

      // Unused encodings 6/7 fall back to sequential fetch.
      case (PCSrc)
         PC_NEXT:   w_next.next_pc = w_pc4;
         PC_BRANCH: w_next.next_pc = w_br;
         PC_JUMP:   w_next.next_pc = w_jt;
         PC_JR:     w_next.next_pc = DataBusA;
         PC_ILLOP:  w_next.next_pc = ILLOP_ADDR;
         PC_XADR:   w_next.next_pc = XADR_ADDR;
         default:   w_next.next_pc = w_pc4;
      endcase

      case (RegDst)
         RD_RD:   w_next.wr_reg = {27'b0, w_rd};
         RD_RT:   w_next.wr_reg = {27'b0, w_rt};
         RD_RA:   w_next.wr_reg = {27'b0, RA_REG};
         default: w_next.wr_reg = {27'b0, XP_REG};
      endcase

      case (MemToReg)
         WB_ALU:  w_next.wb_data = ALUOUT;
         WB_MEM:  w_next.wb_data = ReadData;
         WB_PC4:  w_next.wb_data = w_pc4;
         default: w_next.wb_data = PC;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_result <= '0;
      else
         r_result <= w_next;
   end

   assign RESULT_ALUSrc1  = r_result.alu_a;
   assign RESULT_ALUSrc2  = r_result.alu_b;
   assign RESULT_PCSrc    = r_result.next_pc;
   assign RESULT_RegDst   = r_result.wr_reg;
   assign RESULT_MemToReg = r_result.wb_data;

endmodule

// File: tb/tb_mux_choose_signal.sv
// Self-checking bench for mux_choose_signal: expected results are queued when
// stimulus is applied and compared one clock edge later.
module tb_mux_choose_signal;

   logic        clk;
   logic        rst_n;
   logic [2:0]  pc_src;
   logic [1:0]  reg_dst;
   logic        alu_src1;
   logic        alu_src2;
   logic [1:0]  mem_to_reg;
   logic        ext_op;
   logic        lu_op;
   logic [31:0] instr;
   logic [31:0] bus_a;
   logic [31:0] bus_b;
   logic [31:0] alu_out;
   logic [31:0] rd_data;
   logic [31:0] pc;
   logic [31:0] res_a;
   logic [31:0] res_b;
   logic [31:0] res_pc;
   logic [31:0] res_rd;
   logic [31:0] res_wb;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] pc;
      logic [31:0] rd;
      logic [31:0] wb;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   mux_choose_signal dut (
      .clk             (clk),
      .reset           (rst_n),
      .PCSrc           (pc_src),
      .RegDst          (reg_dst),
      .ALUSrc1         (alu_src1),
      .ALUSrc2         (alu_src2),
      .MemToReg        (mem_to_reg),
      .EXTOp           (ext_op),
      .LUOp            (lu_op),
      .instruction     (instr),
      .DataBusA        (bus_a),
      .DataBusB        (bus_b),
      .ALUOUT          (alu_out),
      .ReadData        (rd_data),
      .PC              (pc),
      .RESULT_ALUSrc1  (res_a),
      .RESULT_ALUSrc2  (res_b),
      .RESULT_PCSrc    (res_pc),
      .RESULT_RegDst   (res_rd),
      .RESULT_MemToReg (res_wb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got %h expected %h", tag, act, exp);
   endtask

   // Reference behaviour derived from the instruction-field definitions.
   function automatic exp_t model();
      exp_t        e;
      logic [31:0] pc4;
      logic [31:0] sext;
      logic [31:0] ext;
      pc4  = pc + 32'd4;
      sext = {{16{instr[15]}}, instr[15:0]};
      if (lu_op)       ext = {instr[15:0], 16'h0};
      else if (ext_op) ext = sext;
      else             ext = {16'h0, instr[15:0]};
      e.a = alu_src1 ? {27'b0, instr[10:6]} : bus_a;
      e.b = alu_src2 ? ext : bus_b;
      case (pc_src)
         3'd1:    e.pc = pc4 + {sext[29:0], 2'b00};
         3'd2:    e.pc = {pc4[31:28], instr[25:0], 2'b00};
         3'd3:    e.pc = bus_a;
         3'd4:    e.pc = 32'h8000_0004;
         3'd5:    e.pc = 32'h8000_0008;
         default: e.pc = pc4;
      endcase
      case (reg_dst)
         2'd0:    e.rd = {27'b0, instr[15:11]};
         2'd1:    e.rd = {27'b0, instr[20:16]};
         2'd2:    e.rd = 32'd31;
         default: e.rd = 32'd26;
      endcase
      case (mem_to_reg)
         2'd0:    e.wb = alu_out;
         2'd1:    e.wb = rd_data;
         2'd2:    e.wb = pc4;
         default: e.wb = pc;
      endcase
      return e;
   endfunction

   task automatic compare_outputs(input string tag);
      exp_t e;
      if (sb_q.size() == 0) begin
         check_val({tag, "_sb_empty"}, 32'd1, 32'd0);
         return;
      end
      e = sb_q.pop_front();
      check_val({tag, "_alu_a"}, res_a,  e.a);
      check_val({tag, "_alu_b"}, res_b,  e.b);
      check_val({tag, "_pc"},    res_pc, e.pc);
      check_val({tag, "_rd"},    res_rd, e.rd);
      check_val({tag, "_wb"},    res_wb, e.wb);
   endtask

   // Apply selects between edges, queue the expectation, compare after the edge.
   task automatic step(input string tag, input logic [2:0] ps, input logic [1:0] rd,
                       input logic a1, input logic a2, input logic [1:0] m2r,
                       input logic ext, input logic lu);
      @(negedge clk);
      pc_src = ps; reg_dst = rd; alu_src1 = a1; alu_src2 = a2;
      mem_to_reg = m2r; ext_op = ext; lu_op = lu;
      sb_q.push_back(model());
      @(posedge clk);
      #1;
      compare_outputs(tag);
   endtask

   task automatic check_zero(input string tag);
      check_val({tag, "_alu_a"}, res_a,  32'h0);
      check_val({tag, "_alu_b"}, res_b,  32'h0);
      check_val({tag, "_pc"},    res_pc, 32'h0);
      check_val({tag, "_rd"},    res_rd, 32'h0);
      check_val({tag, "_wb"},    res_wb, 32'h0);
   endtask

   initial begin
      logic [31:0] pc_tab [8];
      logic [31:0] rd_tab [4];
      logic [31:0] wb_tab [4];
      pc_tab = '{32'h0040_0004, 32'h003E_A084, 32'h038E_A080, 32'hFFFF_FFFF,
                 32'h8000_0004, 32'h8000_0008, 32'h0040_0004, 32'h0040_0004};
      rd_tab = '{32'd21, 32'd3, 32'd31, 32'd26};
      wb_tab = '{32'hAAAA_AAAA, 32'h07C1_F07C, 32'h0040_0004, 32'h0040_0000};

      rst_n = 1'b0;
      pc_src = 3'd5; reg_dst = 2'd2; alu_src1 = 1'b1; alu_src2 = 1'b1;
      mem_to_reg = 2'd3; ext_op = 1'b1; lu_op = 1'b0;
      instr   = 32'h00E3_A820;
      pc      = 32'h0040_0000;
      bus_a   = 32'hFFFF_FFFF;
      bus_b   = 32'h0;
      alu_out = 32'hAAAA_AAAA;
      rd_data = 32'h07C1_F07C;

      #2;
      check_zero("rst_async");
      repeat (2) @(posedge clk);
      #1;
      check_zero("rst_hold");

      @(negedge clk);
      rst_n = 1'b1;
      step("first", 3'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
      check_val("first_pc_const", res_pc, 32'h0040_0004);
      check_val("first_rd_const", res_rd, 32'd21);

      for (int i = 0; i < 4; i++) begin
         step($sformatf("regdst%0d", i), 3'd0, 2'(i), 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
         check_val($sformatf("regdst%0d_const", i), res_rd, rd_tab[i]);
      end

      for (int i = 0; i < 8; i++) begin
         step($sformatf("pcsrc%0d", i), 3'(i), 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
         check_val($sformatf("pcsrc%0d_const", i), res_pc, pc_tab[i]);
      end

      // Branch target must ignore EXTOp/LUOp.
      step("pcsrc1_lu", 3'd1, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
      check_val("pcsrc1_lu_const", res_pc, 32'h003E_A084);

      for (int i = 0; i < 4; i++) begin
         step($sformatf("m2r%0d", i), 3'd0, 2'd0, 1'b0, 1'b0, 2'(i), 1'b0, 1'b0);
         check_val($sformatf("m2r%0d_const", i), res_wb, wb_tab[i]);
      end

      step("alusrc1", 3'd0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
      check_val("alusrc1_const", res_a, 32'h0);
      step("zext", 3'd0, 2'd0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
      check_val("zext_const", res_b, 32'h0000_A820);
      step("lui", 3'd0, 2'd0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1);
      check_val("lui_const", res_b, 32'hA820_0000);
      step("sext", 3'd0, 2'd0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0);
      check_val("sext_const", res_b, 32'hFFFF_A820);

      // Mixed selects changing together.
      step("mix", 3'd2, 2'd3, 1'b1, 1'b1, 2'd2, 1'b1, 1'b1);

      @(negedge clk);
      pc = 32'hFFFF_FFFC;
      step("wrap", 3'd0, 2'd1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0);
      check_val("wrap_pc_const", res_pc, 32'h0000_0000);
      check_val("wrap_wb_const", res_wb, 32'h0000_0000);

      // Mid-stream reset: new selects applied, then reset drops before the edge.
      @(negedge clk);
      pc = 32'h0040_0000;
      pc_src = 3'd4; reg_dst = 2'd2; mem_to_reg = 2'd1;
      #1;
      rst_n = 1'b0;
      #1;
      check_zero("rst_mid");
      sb_q.delete();
      @(posedge clk);
      #1;
      check_zero("rst_mid_hold");

      @(negedge clk);
      rst_n = 1'b1;
      step("post_rst", 3'd5, 2'd2, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0);
      check_val("post_rst_pc_const", res_pc, 32'h8000_0008);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
